// File: rtl/audio_pkg.sv
// Shared audio constants, ramp state type, control payload and duty/gain helpers
// used by the sine generator and the PWM output stage.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned GAIN_W   = 5;
  localparam int unsigned PROD_W   = SAMPLE_W + 1 + GAIN_W;
  localparam int unsigned MIDSCALE = 128;
  localparam int unsigned GAIN_MAX = 16;

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} ramp_state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] sample;
    logic [GAIN_W-1:0]   volume;
    logic                mute;
  } audio_ctrl_t;

  // Mute overrides volume; volume saturates at GAIN_MAX.
  function automatic logic [GAIN_W-1:0] target_gain(input logic mute,
                                                    input logic [GAIN_W-1:0] volume);
    if (mute) return '0;
    return (volume > GAIN_W'(GAIN_MAX)) ? GAIN_W'(GAIN_MAX) : volume;
  endfunction

  // Scale the offset-binary sample about midscale by gain/16 (arithmetic shift floors).
  function automatic logic [PWM_BITS-1:0] scaled_duty(input logic [SAMPLE_W-1:0] sample,
                                                      input logic [GAIN_W-1:0]   gain);
    logic signed [PROD_W-1:0] offs;
    logic signed [PROD_W-1:0] prod;
    offs = $signed(PROD_W'(sample)) - $signed(PROD_W'(MIDSCALE));
    prod = offs * $signed(PROD_W'(gain));
    return PWM_BITS'(prod >>> 4) + PWM_BITS'(MIDSCALE);
  endfunction

endpackage

// File: rtl/audio_pwm_out_if.sv
// Control/status bundle between the song player and the PWM output stage.
interface audio_pwm_out_if;
  import audio_pkg::*;

  audio_ctrl_t       ctrl;
  logic              pwm;
  logic              period_start;
  logic              muted;
  logic [GAIN_W-1:0] gain;

  modport master (output ctrl, input pwm, period_start, muted, gain);
  modport slave  (input ctrl, output pwm, period_start, muted, gain);
endinterface

// File: rtl/audio_pwm_out_gain_ramp.sv
// Applied-gain register; with AUDIO_PWM_RAMP_EN it slews one step per RAMP_DIV
// PWM periods toward the target, otherwise it follows the target each period.
module gain_ramp
  import audio_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boundary_i,
  input  logic [GAIN_W-1:0] tgt_i,
  output logic [GAIN_W-1:0] g_o,
  output logic [GAIN_W-1:0] g_next_c,
  output logic              muted_c
);

  if (RAMP_DIV < 1) begin : g_bad_ramp_div
    $error("gain_ramp: RAMP_DIV must be at least 1");
  end

  logic [GAIN_W-1:0] g_q, g_d;

`ifdef AUDIO_PWM_RAMP_EN
  localparam int unsigned PC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(RAMP_DIV - 1);

  ramp_state_t     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      g_q     <= g_d;
    end
  end

  // Direction follows the target each boundary, so a mid-ramp reversal keeps pc.
  always_comb begin
    state_d = state_q;
    if (boundary_i) begin
      if (g_d == tgt_i)     state_d = IDLE;
      else if (g_d < tgt_i) state_d = RAMP_UP;
      else                  state_d = RAMP_DOWN;
    end
  end

  // The boundary that leaves IDLE counts as the first period of the ramp.
  always_comb begin
    g_d  = g_q;
    pc_d = pc_q;
    if (boundary_i) begin
      if (g_q == tgt_i) begin
        pc_d = '0;
      end else if (pc_q == PC_LAST) begin
        pc_d = '0;
        g_d  = (g_q < tgt_i) ? GAIN_W'(g_q + 1'b1) : GAIN_W'(g_q - 1'b1);
      end else begin
        pc_d = PC_W'(pc_q + 1'b1);
      end
    end
  end

  assign muted_c = (g_q == '0) && (tgt_i == '0);
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) g_q <= '0;
    else      g_q <= g_d;
  end

  always_comb begin
    g_d = g_q;
    if (boundary_i) g_d = tgt_i;
  end

  assign muted_c = (g_q == '0);
`endif

  assign g_o      = g_q;
  assign g_next_c = g_d;

endmodule

// File: rtl/audio_pwm_out.sv
// Sample-to-PWM output stage with gain scaling about midscale.
// Optional gain slew enabled by defining AUDIO_PWM_RAMP_EN.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 256
) (
  input  logic            clk,
  input  logic            rst,
  audio_pwm_out_if.slave  bus
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;
  logic                ps_q, ps_d;
  logic                started_q, started_d;
  logic                boundary_c;
  logic [GAIN_W-1:0]   tgt_c;
  logic [GAIN_W-1:0]   g_q;
  logic [GAIN_W-1:0]   g_next_c;
  logic                muted_c;

  assign boundary_c = &cnt_q;
  assign tgt_c      = target_gain(bus.ctrl.mute, bus.ctrl.volume);

  gain_ramp #(.RAMP_DIV(RAMP_DIV)) u_gain_ramp (
    .clk        (clk),
    .rst        (rst),
    .boundary_i (boundary_c),
    .tgt_i      (tgt_c),
    .g_o        (g_q),
    .g_next_c   (g_next_c),
    .muted_c    (muted_c)
  );

  // period_start is held off until the first wrap after reset.
  always_comb begin
    cnt_d     = PWM_BITS'(cnt_q + 1'b1);
    duty_d    = duty_q;
    started_d = started_q;
    if (boundary_c) begin
      duty_d    = scaled_duty(bus.ctrl.sample, g_next_c);
      started_d = 1'b1;
    end
    pwm_d = (cnt_q < duty_q);
    ps_d  = (cnt_q == '0) && started_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      duty_q    <= PWM_BITS'(MIDSCALE);
      pwm_q     <= 1'b0;
      ps_q      <= 1'b0;
      started_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
      started_q <= started_d;
    end
  end

  assign bus.pwm          = pwm_q;
  assign bus.period_start = ps_q;
  assign bus.gain         = g_q;
  assign bus.muted        = muted_c;

endmodule

// File: doc/audio_pwm_out.md
# audio_pwm_out

Output stage that turns the 8-bit unsigned sine amplitude from the song player into a single-bit PWM drive for the speaker/buzzer pin. Each PWM period, the block captures one sample, scales it about midscale by a 0–16 gain, and emits a duty cycle proportional to the result. A mute/volume gain ramp steps the gain one unit at a time, so mute and volume changes do not click. It sits directly downstream of the sine generator output and is the last logic before the pad.

## Interface
- PWM_BITS, 8: counter width; one PWM period is 2^PWM_BITS clocks.
- RAMP_DIV, 256: PWM periods between gain steps (ramp build only); legal range ≥1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sample  in  8  unsigned offset-binary amplitude; 128 = silence.
- volume  in  5  target gain 0..16; values >16 are clamped to 16.
- mute  in  1  level; forces the target gain to 0.
- pwm  out  1  registered PWM drive.
- period_start  out  1  one-cycle pulse in the first cycle of each PWM period.
- muted  out  1  high when the applied gain is 0 and the target is 0.
- gain  out  5  currently applied gain.

## Operation
- Free-running counter cnt, 0..255, wraps 255→0.
- Boundary cycle = cycle where cnt==255. On that edge:
  - sample is captured.
  - The gain is updated (see ramp).
  - duty is loaded with: duty = 128 + ((signed(sample)−128) × g_new) >>> 4.
  - Arithmetic: 9-bit signed × 5-bit unsigned gives a 14-bit signed product; shift is arithmetic. The result is always in 0..255, so no saturation logic is needed.
- pwm ← (cnt < duty) every cycle. duty 0 gives constant low; duty 255 gives high for 255 of 256 clocks.
- Target gain tgt = mute ? 0 : min(volume, 16).
- Ramp FSM, states IDLE, RAMP_UP, RAMP_DOWN, evaluated only on boundary cycles:
  - IDLE: if g<tgt → RAMP_UP; if g>tgt → RAMP_DOWN.
  - RAMP_UP / RAMP_DOWN: a period counter counts to RAMP_DIV−1. At that count, g moves ±1 toward tgt and the period counter clears. When g reaches tgt → IDLE.
  - If tgt crosses to the other side of g mid-ramp, switch direction directly and keep the period count.
- muted = (g==0) && (tgt==0). It is combinational from registers.
- sample, volume and mute are sampled only on boundary cycles. Changes between boundaries have no effect.

## Timing
- Reset values:
  - cnt=0, duty=128, g=0, ramp counter 0, FSM IDLE.
  - pwm=0, period_start=0, gain=0.
  - muted = 1 if mute is asserted or volume==0, else 0.
- Latency, sample to output: a sample captured on the boundary edge affects pwm starting the cycle after cnt becomes 0. There is one register stage on pwm.
- period_start is registered: high exactly one cycle, aligned with the first pwm bit of the new period. It is first asserted after the first wrap following reset.
- Reset asserted mid-period: all state clears immediately (asynchronously). The first post-reset period begins at cnt=0 with duty 128.
- Simultaneous mute assertion and volume change on a boundary: mute wins; tgt=0.
- Worst-case ramp time, 0↔16: 16 × RAMP_DIV periods.

## Configuration
- AUDIO_PWM_RAMP_EN defined: gain ramp FSM as described.
- AUDIO_PWM_RAMP_EN undefined:
  - No FSM and no ramp counter.
  - g ← tgt on every boundary cycle.
  - RAMP_DIV is ignored.
  - muted = (g==0).

## Structure
- Shared package audio_pkg holds:
  - MIDSCALE=128 and GAIN_MAX=16.
  - The ramp_state_t enum {IDLE, RAMP_UP, RAMP_DOWN}.
  - The width constants used by the sine generator and this block.
- One sub-module, gain_ramp:
  - Owns the FSM, the period counter and g.
  - Inputs: boundary strobe, tgt.
  - Compiled as a pass-through register when AUDIO_PWM_RAMP_EN is absent.
- The top level keeps the PWM counter, the multiply/offset datapath and the output registers.

## Test plan
- Reset with volume=16, mute=0, ramp disabled; sample=200 held → after the first boundary, every period has exactly 200 high cycles; period_start fires every 256 clocks.
- Ramp disabled, volume=8: sample=200 → 164 high cycles; sample=50 → 89; sample=0 → 64; sample=128 → 128.
- Ramp enabled, RAMP_DIV=4, volume=16 from reset:
  - gain increments every 4 periods and reaches 16 after 64 periods.
  - With sample=255, duty walks 128→255.
- Ramp enabled, at g=16: assert mute → g steps down to 0 over 64 periods; muted rises on the boundary where g hits 0. Deassert mute at g=8 → direction reverses without skipping a step.
- Boundary extremes at volume=16: sample=0 → pwm constant low; sample=255 → high 255 of 256 clocks. No wrap or overflow in duty.
- Assert rst at cnt=100 mid-period → pwm, gain and period_start go to 0 immediately. After release, cnt restarts at 0 and duty is 128 for the first period.
